mcs_mmio_bridge: RTL and testbench

Registered bridge between the processor IO bus and the MMIO slot bus of the MMIO subsystem. It decodes the bridge address window and converts each processor strobe into a single-cycle slot-bus read or write. Partial-byte writes become read-modify-write sequences, because slot cores accept only full 32-bit writes. It returns completion and read data to the processor with a one-cycle `io_ready` pulse, and it flags illegal accesses.

---
 rtl/mcs_mmio_bridge.sv | 156 +++++++++++++++
 tb/tb_mcs_mmio_bridge.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcs_mmio_bridge.sv
// Processor IO bus to MMIO slot bus bridge: window decode, single-cycle slot
// accesses, read-modify-write for partial writes, sticky bus error flag.
//
// state  | meaning
// IDLE   | waiting for an accepted processor request
// RD     | slot read, return data latched
// WR     | full-word slot write
// RMW_RD | slot read of the word being partially written
// RMW_WR | merged full-word slot write
// DONE   | io_ready pulse back to the processor
module mcs_mmio_bridge #(
  parameter logic [31:0] BRIDGE_BASE = 32'hC000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_addr_strobe,
  input  logic        io_read_strobe,
  input  logic        io_write_strobe,
  input  logic [3:0]  io_byte_enable,
  input  logic [31:0] io_address,
  input  logic [31:0] io_write_data,
  output logic [31:0] io_read_data,
  output logic        io_ready,
  output logic        mmio_cs,
  output logic        mmio_wr,
  output logic        mmio_rd,
  output logic [20:0] mmio_addr,
  output logic [31:0] mmio_wr_data,
  input  logic [31:0] mmio_rd_data,
  input  logic        err_clr,
  output logic        bus_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_WR     = 3'd2;
  localparam logic [2:0] S_RMW_RD = 3'd3;
  localparam logic [2:0] S_RMW_WR = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [20:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        cs_q, cs_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        ready_q, ready_d;

  logic req_rd, req_wr, req_both, in_win;
  logic unused_addr_lsb;

  assign req_rd   = io_addr_strobe & io_read_strobe & ~io_write_strobe;
  assign req_wr   = io_addr_strobe & io_write_strobe & ~io_read_strobe;
  assign req_both = io_addr_strobe & io_read_strobe & io_write_strobe;
  assign in_win   = (io_address[31:23] == BRIDGE_BASE[31:23]);
  assign unused_addr_lsb = ^io_address[1:0];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    wr_data_d = wr_data_q;
    rdata_d   = rdata_q;
    err_d     = err_clr ? 1'b0 : err_q;

    case (state_q)
      S_IDLE: begin
        if (req_both) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else if (req_rd || req_wr) begin
          addr_d  = io_address[22:2];
          be_d    = io_byte_enable;
          wdata_d = io_write_data;
          if (!in_win) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            if (req_rd) rdata_d = 32'h0;
          end else if (req_rd) begin
            state_d = S_RD;
          end else if (io_byte_enable == 4'b1111) begin
            state_d   = S_WR;
            wr_data_d = io_write_data;
          end else if (io_byte_enable == 4'b0000) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_RD: begin
        rdata_d = mmio_rd_data;
        state_d = S_DONE;
      end
      S_WR:     state_d = S_DONE;
      S_RMW_RD: begin
        // merge happens here so the write cycle only replays a register
        for (int k = 0; k < 4; k++)
          wr_data_d[8*k +: 8] = be_q[k] ? wdata_q[8*k +: 8] : mmio_rd_data[8*k +: 8];
        state_d = S_RMW_WR;
      end
      S_RMW_WR: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    cs_d    = (state_d == S_RD) || (state_d == S_WR) ||
              (state_d == S_RMW_RD) || (state_d == S_RMW_WR);
    rd_d    = (state_d == S_RD) || (state_d == S_RMW_RD);
    wr_d    = (state_d == S_WR) || (state_d == S_RMW_WR);
    ready_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      wr_data_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cs_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      wr_data_q <= wr_data_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cs_q      <= cs_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      ready_q   <= ready_d;
    end
  end

  assign io_read_data = rdata_q;
  assign io_ready     = ready_q;
  assign mmio_cs      = cs_q;
  assign mmio_rd      = rd_q;
  assign mmio_wr      = wr_q;
  assign mmio_addr    = addr_q;
  assign mmio_wr_data = wr_data_q;
  assign bus_err      = err_q;

endmodule

// File: tb/tb_mcs_mmio_bridge.sv
// Bench for mcs_mmio_bridge: table of single transactions against a word
// memory slot model, a read-data scoreboard, and hand-written corner sequences.
module tb_mcs_mmio_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_addr_strobe = 1'b0;
  logic        io_read_strobe = 1'b0;
  logic        io_write_strobe = 1'b0;
  logic [3:0]  io_byte_enable = 4'h0;
  logic [31:0] io_address = 32'h0;
  logic [31:0] io_write_data = 32'h0;
  logic [31:0] io_read_data;
  logic        io_ready;
  logic        mmio_cs, mmio_wr, mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data;
  logic [31:0] mmio_rd_data;
  logic        err_clr = 1'b0;
  logic        bus_err;

  mcs_mmio_bridge dut (
    .clk(clk), .reset(reset),
    .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
    .io_write_strobe(io_write_strobe), .io_byte_enable(io_byte_enable),
    .io_address(io_address), .io_write_data(io_write_data),
    .io_read_data(io_read_data), .io_ready(io_ready),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_data(mmio_rd_data), .err_clr(err_clr), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  assign mmio_rd_data = mmio_rd ? mem[mmio_addr[7:0]] : 32'hDEAD_BEEF;

  typedef struct {
    bit          chk;
    logic [31:0] rdata;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    bit          rd;
    bit          wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] slot;
    int          lat;
    logic [31:0] rdata;
    bit          err;
    int          nrd;
    int          nwr;
    logic [31:0] slot_after;
    bit          clr_first;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic [20:0] last_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // slot model, strobe counters and scoreboard pop on completion
  always @(negedge clk) begin
    if (!reset) begin
      if (mmio_rd) begin
        rd_cnt++;
        last_addr = mmio_addr;
      end
      if (mmio_wr) begin
        wr_cnt++;
        last_addr = mmio_addr;
        mem[mmio_addr[7:0]] = mmio_wr_data;
      end
      if (mmio_rd && mmio_wr) begin
        errors++;
        $display("FAIL rd_wr_overlap: got rd=1 wr=1 expected at most one");
      end
      if (mmio_cs !== (mmio_rd | mmio_wr)) begin
        errors++;
        $display("FAIL cs_decode: got cs=%b expected %b", mmio_cs, mmio_rd | mmio_wr);
      end
      if (io_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_ready: got io_ready=1 expected no completion");
        end else begin
          sb_t e;
          e = sb.pop_front();
          if (e.chk && io_read_data !== e.rdata) begin
            errors++;
            $display("FAIL read_data: got %h expected %h", io_read_data, e.rdata);
          end
        end
      end
    end
  end

  task automatic wait_ready(output int lat);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (io_ready) begin
        lat = n;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int   lat;
    sb_t  e;
    logic [7:0] idx;
    if (v.clr_first) pulse_clr();
    idx = v.addr[9:2];
    mem[idx] = v.slot;
    rd_cnt = 0;
    wr_cnt = 0;
    e.chk = v.rd && !v.wr;
    e.rdata = v.rdata;
    sb.push_back(e);
    io_addr_strobe  = 1'b1;
    io_read_strobe  = v.rd;
    io_write_strobe = v.wr;
    io_byte_enable  = v.be;
    io_address      = v.addr;
    io_write_data   = v.wdata;
    @(posedge clk);
    #1;
    io_addr_strobe  = 1'b0;
    io_read_strobe  = 1'b0;
    io_write_strobe = 1'b0;
    wait_ready(lat);
    chk($sformatf("v%0d_latency", id), lat, v.lat);
    chk($sformatf("v%0d_bus_err", id), {31'b0, bus_err}, {31'b0, v.err});
    chk($sformatf("v%0d_rd_count", id), rd_cnt, v.nrd);
    chk($sformatf("v%0d_wr_count", id), wr_cnt, v.nwr);
    chk($sformatf("v%0d_slot_word", id), mem[idx], v.slot_after);
    if (v.nrd + v.nwr > 0)
      chk($sformatf("v%0d_mmio_addr", id), {11'b0, last_addr}, {11'b0, v.addr[22:2]});
  endtask

  vec_t vecs [10];

  initial begin
    int   lat;
    int   ready_seen;
    sb_t  e;

    vecs[0] = '{1, 0, 4'hF, 32'hC000_0104, 32'h0, 32'hA5A5_1234, 2, 32'hA5A5_1234, 0, 1, 0, 32'hA5A5_1234, 0};
    vecs[1] = '{0, 1, 4'hF, 32'hC000_0208, 32'h0000_00FF, 32'hDEAD_BEEF, 2, 32'h0, 0, 0, 1, 32'h0000_00FF, 0};
    vecs[2] = '{0, 1, 4'b0100, 32'hC000_0300, 32'h00AB_0000, 32'h1122_3344, 3, 32'h0, 0, 1, 1, 32'h11AB_3344, 0};
    vecs[3] = '{0, 1, 4'b1001, 32'hC000_0010, 32'hAABB_CCDD, 32'h1122_3344, 3, 32'h0, 0, 1, 1, 32'hAA22_33DD, 0};
    vecs[4] = '{0, 1, 4'b0000, 32'hC000_0020, 32'hFFFF_FFFF, 32'h0000_0055, 1, 32'h0, 0, 0, 0, 32'h0000_0055, 0};
    vecs[5] = '{1, 0, 4'h0, 32'hC07F_FFFC, 32'h0, 32'h0BAD_F00D, 2, 32'h0BAD_F00D, 0, 1, 0, 32'h0BAD_F00D, 0};
    vecs[6] = '{1, 0, 4'hF, 32'h4000_0000, 32'h0, 32'h1234_5678, 1, 32'h0, 1, 0, 0, 32'h1234_5678, 0};
    vecs[7] = '{0, 1, 4'b0000, 32'hC000_0024, 32'h0, 32'h0000_0066, 1, 32'h0, 1, 0, 0, 32'h0000_0066, 0};
    vecs[8] = '{0, 1, 4'hF, 32'hC080_0000, 32'hCAFE_CAFE, 32'h0000_0077, 1, 32'h0, 1, 0, 0, 32'h0000_0077, 0};
    vecs[9] = '{1, 1, 4'hF, 32'hC000_0104, 32'hFFFF_FFFF, 32'h0000_0088, 1, 32'h0, 1, 0, 0, 32'h0000_0088, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_strobes", {28'b0, io_ready, mmio_cs, mmio_rd, mmio_wr}, 32'h0);
    chk("reset_bus_err", {31'b0, bus_err}, 32'h0);
    chk("reset_read_data", io_read_data, 32'h0);
    chk("reset_mmio_addr", {11'b0, mmio_addr}, 32'h0);
    chk("reset_wr_data", mmio_wr_data, 32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // err_clr alone clears the sticky flag
    pulse_clr();
    chk("err_clr_clears", {31'b0, bus_err}, 32'h0);

    // err_clr together with a new error: set wins
    e.chk = 1'b1;
    e.rdata = 32'h0;
    sb.push_back(e);
    io_addr_strobe = 1'b1;
    io_read_strobe = 1'b1;
    io_address     = 32'h8000_0000;
    err_clr        = 1'b1;
    @(posedge clk);
    #1;
    io_addr_strobe = 1'b0;
    io_read_strobe = 1'b0;
    err_clr        = 1'b0;
    chk("set_beats_clr", {31'b0, bus_err}, 32'h1);
    @(negedge clk);
    chk("oow_coincide_ready", {31'b0, io_ready}, 32'h1);
    @(posedge clk);
    #1;

    // strobe while in RD is dropped
    mem[8'h41] = 32'hA5A5_1234;
    mem[8'h10] = 32'h0000_0077;
    rd_cnt = 0;
    wr_cnt = 0;
    e.chk = 1'b1;
    e.rdata = 32'hA5A5_1234;
    sb.push_back(e);
    io_addr_strobe = 1'b1;
    io_read_strobe = 1'b1;
    io_address     = 32'hC000_0104;
    @(posedge clk);
    #1;
    io_read_strobe  = 1'b0;
    io_write_strobe = 1'b1;
    io_byte_enable  = 4'hF;
    io_address      = 32'hC000_0040;
    io_write_data   = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    io_addr_strobe  = 1'b0;
    io_write_strobe = 1'b0;
    ready_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (io_ready) ready_seen++;
    end
    chk("busy_ready_count", ready_seen, 1);
    chk("busy_wr_count", wr_cnt, 0);
    chk("busy_slot_untouched", mem[8'h10], 32'h0000_0077);
    @(posedge clk);
    #1;

    // reset in RMW_RD abandons the partial write
    mem[8'hC0] = 32'h1122_3344;
    io_addr_strobe  = 1'b1;
    io_write_strobe = 1'b1;
    io_byte_enable  = 4'b0100;
    io_address      = 32'hC000_0300;
    io_write_data   = 32'h00AB_0000;
    @(posedge clk);
    #1;
    io_addr_strobe  = 1'b0;
    io_write_strobe = 1'b0;
    chk("rmw_rd_active", {31'b0, mmio_rd}, 32'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_strobes", {28'b0, io_ready, mmio_cs, mmio_rd, mmio_wr}, 32'h0);
    chk("rst_mid_read_data", io_read_data, 32'h0);
    chk("rst_mid_mmio_addr", {11'b0, mmio_addr}, 32'h0);
    chk("rst_mid_wr_data", mmio_wr_data, 32'h0);
    chk("rst_mid_bus_err", {31'b0, bus_err}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    rd_cnt = 0;
    wr_cnt = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_no_write", wr_cnt, 0);
    chk("rst_slot_intact", mem[8'hC0], 32'h1122_3344);
    chk("rst_sb_empty", sb.size(), 0);

    run_vec(vecs[0], 10);

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
